// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice.
//   WORD / ADDR     : data and address widths (16 bits each)
//   word_t / addr_t : convenience types for those widths
//   arb_state_t     : access state machine encoding (ARB_IDLE/ARB_ACCESS/ARB_DONE)
//   arb_owner_t     : which requester owns the current access (OWN_CPU=0, OWN_HOST=1)
//   cnt_width()     : width of a counter that must hold values 0..maxval
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

   localparam int WORD = 16;
   localparam int ADDR = 16;

   typedef logic [WORD-1:0] word_t;
   typedef logic [ADDR-1:0] addr_t;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CPU  = 1'b0,
      OWN_HOST = 1'b1
   } arb_owner_t;

   // A counter holding 0..maxval needs clog2(maxval+1) bits; never go below
   // one bit so a degenerate range still yields a legal vector.
   function automatic int cnt_width(input int maxval);
      return (maxval > 1) ? $clog2(maxval + 1) : 1;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports and the memory port of the arbiter.
//   cpu_*  : load/store stage request, grant, completion and read data
//   host_* : host/debug loader, identical shape to the cpu port
//   mem_*  : single-port data memory (enable, write enable, address, data)
//   busy   : arbiter is not idle
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters plus memory array)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
   import dmem_arbiter_pkg::*;

   logic  cpu_req;
   logic  cpu_we;
   addr_t cpu_addr;
   word_t cpu_wdata;
   logic  cpu_gnt;
   logic  cpu_rvalid;
   word_t cpu_rdata;

   logic  host_req;
   logic  host_we;
   addr_t host_addr;
   word_t host_wdata;
   logic  host_gnt;
   logic  host_rvalid;
   word_t host_rdata;

   logic  mem_en;
   logic  mem_we;
   addr_t mem_addr;
   word_t mem_wdata;
   word_t mem_rdata;

   logic  busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  host_req, host_we, host_addr, host_wdata,
      input  mem_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      output host_gnt, host_rvalid, host_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output host_req, host_we, host_addr, host_wdata,
      output mem_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      input  host_gnt, host_rvalid, host_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );

endinterface

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner select between the cpu and host requesters.
//   cpu_req  : cpu is requesting
//   host_req : host is requesting
//   starve   : host has waited through the maximum run of cpu grants
//   any_req  : at least one requester is asking
//   owner    : winner (only meaningful while any_req is high)
// The cpu wins every contest unless the starve flag hands it to the host.
// ---------------------------------------------------------------------------
module dmem_arb_pick
   import dmem_arbiter_pkg::*;
(
   input  logic       cpu_req,
   input  logic       host_req,
   input  logic       starve,
   output logic       any_req,
   output arb_owner_t owner
);

   assign any_req = cpu_req | host_req;

   // Host wins when it is alone, or when it is contending and starved.
   assign owner = (host_req && (!cpu_req || starve)) ? OWN_HOST : OWN_CPU;

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port 16-bit data memory between the pipeline load/store
// stage (cpu) and a host/debug loader (host). Each granted access holds the
// memory port for MEM_LAT cycles, then pulses the owner's rvalid with the
// captured load data. A new request may be taken at the edge that ends the
// completion cycle, so a requester holding req gets back-to-back service.
//
// Parameters:
//   MEM_LAT    : cycles mem_en is held per access (>= 1)
//   STARVE_MAX : consecutive cpu grants tolerated while host waits (>= 1)
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, clears every output immediately
//   bus   : dmem_arbiter_if.slave (cpu port, host port, memory port, busy)
// Build option:
//   DMEM_ARB_FAIR_EN defined   -> starvation counter forces a host grant
//                                 after STARVE_MAX contested cpu grants
//   DMEM_ARB_FAIR_EN undefined -> strict cpu priority, STARVE_MAX unused
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
)
(
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   localparam int               LAT_W    = cnt_width(MEM_LAT - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   // Reject configurations that would make the counters meaningless.
   generate
      if (MEM_LAT < 1) begin : g_bad_mem_lat
         $error("dmem_arbiter: MEM_LAT must be at least 1");
      end
      if (STARVE_MAX < 1) begin : g_bad_starve_max
         $error("dmem_arbiter: STARVE_MAX must be at least 1");
      end
   endgenerate

   arb_state_t       state;
   arb_owner_t       owner_q;
   logic [LAT_W-1:0] lat_cnt;

   logic             starve;
   logic             any_req;
   arb_owner_t       pick_owner;
   logic             launch;

   dmem_arb_pick u_pick (
      .cpu_req  (bus.cpu_req),
      .host_req (bus.host_req),
      .starve   (starve),
      .any_req  (any_req),
      .owner    (pick_owner)
   );

   // Requests are taken from IDLE and also from DONE, the latter letting a
   // requester that keeps req high start its next access without a gap.
   assign launch = any_req && ((state == ARB_IDLE) || (state == ARB_DONE));

`ifdef DMEM_ARB_FAIR_EN
   localparam int               STV_W   = cnt_width(STARVE_MAX);
   localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

   logic [STV_W-1:0] starve_cnt;

   assign starve = (starve_cnt == STV_MAX);

   // Counts cpu grants that were taken while the host was also waiting.
   // Any host grant, or an uncontested cpu grant, restarts the run; the
   // count saturates so the forced host grant stays pending until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (launch) begin
         if ((pick_owner == OWN_HOST) || !bus.host_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STV_MAX) begin
            starve_cnt <= starve_cnt + STV_W'(1);
         end
      end
   end
`else
   // Strict priority: the host is never forced ahead of the cpu.
   assign starve = 1'b0;
`endif

   // Access state machine with every output registered. Grant and rvalid
   // default low each cycle so they only ever pulse for one clock. On a
   // launch the winner's payload is latched straight onto the memory port;
   // on the last ACCESS cycle the load data is captured into the owner's
   // rdata register (stores leave it untouched) and rvalid is raised for
   // the DONE cycle. The non-owner's outputs are never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ARB_IDLE;
         owner_q         <= OWN_CPU;
         lat_cnt         <= '0;
         bus.cpu_gnt     <= 1'b0;
         bus.cpu_rvalid  <= 1'b0;
         bus.cpu_rdata   <= '0;
         bus.host_gnt    <= 1'b0;
         bus.host_rvalid <= 1'b0;
         bus.host_rdata  <= '0;
         bus.mem_en      <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.busy        <= 1'b0;
      end else begin
         bus.cpu_gnt     <= 1'b0;
         bus.host_gnt    <= 1'b0;
         bus.cpu_rvalid  <= 1'b0;
         bus.host_rvalid <= 1'b0;

         if (launch) begin
            state      <= ARB_ACCESS;
            owner_q    <= pick_owner;
            lat_cnt    <= '0;
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            if (pick_owner == OWN_HOST) begin
               bus.host_gnt  <= 1'b1;
               bus.mem_we    <= bus.host_we;
               bus.mem_addr  <= bus.host_addr;
               bus.mem_wdata <= bus.host_wdata;
            end else begin
               bus.cpu_gnt   <= 1'b1;
               bus.mem_we    <= bus.cpu_we;
               bus.mem_addr  <= bus.cpu_addr;
               bus.mem_wdata <= bus.cpu_wdata;
            end
         end else begin
            case (state)
               ARB_ACCESS: begin
                  if (lat_cnt == LAT_LAST) begin
                     state      <= ARB_DONE;
                     bus.mem_en <= 1'b0;
                     bus.mem_we <= 1'b0;
                     if (owner_q == OWN_HOST) begin
                        bus.host_rvalid <= 1'b1;
                        if (!bus.mem_we) begin
                           bus.host_rdata <= bus.mem_rdata;
                        end
                     end else begin
                        bus.cpu_rvalid <= 1'b1;
                        if (!bus.mem_we) begin
                           bus.cpu_rdata <= bus.mem_rdata;
                        end
                     end
                  end else begin
                     lat_cnt <= lat_cnt + LAT_W'(1);
                  end
               end
               ARB_DONE: begin
                  state    <= ARB_IDLE;
                  bus.busy <= 1'b0;
               end
               default: begin
                  state      <= ARB_IDLE;
                  bus.busy   <= 1'b0;
                  bus.mem_en <= 1'b0;
                  bus.mem_we <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
